// File: rtl/fb_pixel_writer.sv
// Write side of the NES frame buffer: queues PPU palette pixels in a small FIFO and
// writes them to the shared RAM port at linear addresses, flagging frame/stream mismatches.
//
// state    | meaning
// WAIT_SOF | no frame in progress; non-sof pixels are dropped
// ACTIVE   | mid-frame; x/y hold the position of the next pixel
// DONE     | frame complete; only an sof pixel starts the next frame
module fb_pixel_writer #(
  parameter int FB_WIDTH   = 256,
  parameter int FB_HEIGHT  = 240,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [5:0]        pix_data,
  input  logic              pix_sof,
  output logic              fb_we,
  input  logic              fb_grant,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              frame_done,
  output logic              sync_err,
  output logic              ovf_err,
  input  logic              err_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);
  localparam logic [XW-1:0]     X_LAST   = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(FB_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [PW:0]       FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DONE} state_t;

  state_t            state;
  logic [6:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              push, pop, head_sof, sync_set, ovf_set;
  logic [5:0]        head_data;
  logic [ADDR_W-1:0] cur_addr;

  assign pix_ready = !reset && (count != FULL_CNT);
  assign push      = pix_valid && pix_ready;
  // The output register refills when empty or on the cycle its write is taken.
  assign pop       = (count != '0) && (!fb_we || fb_grant);
  assign head_sof  = fifo_mem[rd_ptr][6];
  assign head_data = fifo_mem[rd_ptr][5:0];
  assign cur_addr  = ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
  assign sync_set  = pop && (state == ACTIVE) && head_sof;
  assign ovf_set   = pop && (state == DONE) && !head_sof;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= WAIT_SOF;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      x          <= '0;
      y          <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {pix_sof, pix_data};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

      frame_done <= fb_we && fb_grant && (fb_addr == A_LAST);
      // A set event outranks a same-cycle clear.
      sync_err   <= sync_set || (sync_err && !err_clr);
      ovf_err    <= ovf_set || (ovf_err && !err_clr);

      if (fb_we && fb_grant)
        fb_we <= 1'b0;

      if (pop) begin
        if (head_sof) begin
          fb_we   <= 1'b1;
          fb_addr <= '0;
          fb_data <= {2'b00, head_data};
          x       <= XW'(1);
          y       <= '0;
          state   <= ACTIVE;
        end else begin
          case (state)
            ACTIVE: begin
              fb_we   <= 1'b1;
              fb_addr <= cur_addr;
              fb_data <= {2'b00, head_data};
              if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                  y     <= '0;
                  state <= DONE;
                end else begin
                  y <= y + 1'b1;
                end
              end else begin
                x <= x + 1'b1;
              end
            end
            default: fb_we <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Randomized bench for fb_pixel_writer: a linear-index frame model predicts every
// RAM write, frame_done pulse and error flag from the pixel stream sent in.
module tb_fb_pixel_writer;

  localparam int N = 256 * 240;
  localparam logic [15:0] LAST = 16'(N - 1);

  logic        sysclk = 1'b0;
  logic        reset, pix_valid, pix_ready, pix_sof, fb_we, fb_grant;
  logic        frame_done, sync_err, ovf_err, err_clr;
  logic [5:0]  pix_data;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;

  int n_total = 0;
  int n_bad   = 0;

  logic [6:0]  stim [$];
  logic [21:0] exp_q [$];
  int          pos;
  bit          exp_sync, exp_ovf, saw_full;
  int          push_cnt, grant_cnt, fd_seen, n_writes;

  fb_pixel_writer dut (
    .sysclk(sysclk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .fb_we(fb_we), .fb_grant(fb_grant),
    .fb_addr(fb_addr), .fb_data(fb_data), .frame_done(frame_done),
    .sync_err(sync_err), .ovf_err(ovf_err), .err_clr(err_clr)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // pos: -1 waiting for sof, 0..N-1 next linear index, N frame complete
  function automatic void model_push(input bit sof, input logic [5:0] d);
    if (sof) begin
      if (pos >= 1 && pos < N) exp_sync = 1'b1;
      exp_q.push_back({16'd0, d});
      pos = 1;
    end else if (pos < 0) begin
    end else if (pos >= N) begin
      exp_ovf = 1'b1;
    end else begin
      exp_q.push_back({16'(pos), d});
      pos++;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    pos      = -1;
    exp_sync = 1'b0;
    exp_ovf  = 1'b0;
  endfunction

  task automatic add_stim(input bit sof, input logic [5:0] d);
    stim.push_back({sof, d});
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    @(posedge sysclk); @(negedge sysclk);
    err_clr  = 1'b0;
    exp_sync = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  // mode: 0 grant high, 1 grant 1-of-3, 2 random grant, 3 grant low
  task automatic run(input int mode, input int gap_pct, input bit drain, input int budget);
    int cyc, idle;
    bit push_now, grant_now, fd_exp, held;
    logic [6:0]  s;
    logic [21:0] e;
    logic [15:0] h_addr;
    logic [7:0]  h_data;
    cyc = 0; idle = 0; held = 0;
    while (cyc < budget) begin
      if (!pix_valid && stim.size() > 0 && $urandom_range(99) >= gap_pct) begin
        s = stim.pop_front();
        pix_sof = s[6]; pix_data = s[5:0]; pix_valid = 1'b1;
      end else if (!pix_valid) begin
        pix_sof = 1'($urandom); pix_data = 6'($urandom);
      end
      case (mode)
        0:       fb_grant = 1'b1;
        1:       fb_grant = (cyc % 3 == 0);
        2:       fb_grant = 1'($urandom);
        default: fb_grant = 1'b0;
      endcase
      #1;
      push_now  = pix_valid && pix_ready;
      grant_now = fb_we && fb_grant;
      fd_exp    = 1'b0;
      if (push_now) begin
        model_push(pix_sof, pix_data);
        push_cnt++;
      end
      if (grant_now) begin
        grant_cnt++;
        n_writes++;
        check("wr_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", fb_addr, e[21:6]);
          check("wr_data", fb_data, {2'b00, e[5:0]});
          fd_exp = (e[21:6] == LAST);
        end
      end
      if (mode == 1 && !pix_ready) begin
        saw_full = 1'b1;
        check("full_depth", int'(push_cnt - grant_cnt >= 4), 1);
      end
      held = fb_we && !fb_grant;
      h_addr = fb_addr; h_data = fb_data;
      @(posedge sysclk); @(negedge sysclk);
      if (push_now) pix_valid = 1'b0;
      if (frame_done) fd_seen++;
      check("frame_done", frame_done, fd_exp);
      if (held) begin
        check("hold_we", fb_we, 1);
        check("hold_addr", fb_addr, h_addr);
        check("hold_data", fb_data, h_data);
      end
      cyc++;
      if (stim.size() == 0 && !pix_valid) begin
        if (!drain) break;
        if (exp_q.size() == 0) begin
          idle++;
          if (idle > 8) break;
        end
      end
    end
    check("run_budget", int'(cyc < budget), 1);
    if (drain) check("drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [5:0] d;
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    fb_grant = 1'b0; err_clr = 1'b0;
    push_cnt = 0; grant_cnt = 0; fd_seen = 0; n_writes = 0; saw_full = 1'b0;
    model_reset();
    repeat (3) @(negedge sysclk);
    check("rst_ready", pix_ready, 0);
    check("rst_we", fb_we, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    check("rst_fdone", frame_done, 0);
    check("rst_sync", sync_err, 0);
    check("rst_ovf", ovf_err, 0);
    reset = 1'b0;
    @(posedge sysclk); @(negedge sysclk);
    check("post_rst_ready", pix_ready, 1);

    // 10 stray pixels, then a full frame at one pixel per cycle
    for (int i = 0; i < 10; i++) add_stim(1'b0, 6'($urandom));
    for (int i = 0; i < N; i++) add_stim(i == 0, 6'(i % 64));
    fd_seen = 0; n_writes = 0;
    run(0, 0, 1'b1, 70000);
    check("frame_writes", n_writes, N);
    check("frame_done_cnt", fd_seen, 1);
    check("frame_sync", sync_err, 0);
    check("frame_ovf", ovf_err, 0);

    // pixels past frame end
    for (int i = 0; i < 3; i++) add_stim(1'b0, 6'($urandom));
    n_writes = 0;
    run(2, 10, 1'b1, 200);
    check("extra_writes", n_writes, 0);
    check("extra_ovf", ovf_err, int'(exp_ovf));
    check("extra_sync", sync_err, 0);
    clear_flags();
    check("clr_ovf", ovf_err, 0);

    // minimum latency of an sof pixel, then a throttled frame with an early sof
    push_cnt = 0; grant_cnt = 0; saw_full = 1'b0;
    d = 6'($urandom);
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = d; fb_grant = 1'b0;
    #1;
    check("lat_ready", pix_ready, 1);
    model_push(1'b1, d);
    push_cnt = 1;
    @(posedge sysclk); @(negedge sysclk);
    pix_valid = 1'b0;
    check("lat_we_e0", fb_we, 0);
    @(posedge sysclk); @(negedge sysclk);
    check("lat_we_e1", fb_we, 1);
    check("lat_addr", fb_addr, 0);
    for (int i = 1; i < 300; i++) add_stim(1'b0, 6'($urandom));
    add_stim(1'b1, 6'($urandom));
    for (int i = 0; i < 200; i++) add_stim(1'b0, 6'($urandom));
    run(1, 20, 1'b1, 6000);
    check("early_sof_sync", sync_err, int'(exp_sync));
    check("early_sof_ovf", ovf_err, 0);
    check("fifo_filled", saw_full, 1);
    clear_flags();
    check("clr_sync", sync_err, 0);

    // reset mid-frame with a pending write and three queued pixels
    add_stim(1'b1, 6'($urandom));
    for (int i = 0; i < 3; i++) add_stim(1'b0, 6'($urandom));
    run(3, 0, 1'b0, 50);
    check("pre_rst_we", fb_we, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", pix_ready, 0);
    @(posedge sysclk); @(negedge sysclk);
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_addr", fb_addr, 0);
    reset = 1'b0; fb_grant = 1'b1;
    model_reset();
    @(posedge sysclk); @(negedge sysclk);
    check("after_rst_ready", pix_ready, 1);
    check("after_rst_we", fb_we, 0);
    for (int i = 0; i < 5; i++) add_stim(1'b0, 6'($urandom));
    add_stim(1'b1, 6'($urandom));
    for (int i = 0; i < 20; i++) add_stim(1'b0, 6'($urandom));
    n_writes = 0;
    run(2, 30, 1'b1, 500);
    check("restart_writes", n_writes, 21);
    check("restart_sync", sync_err, 0);
    check("restart_ovf", ovf_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
